// File: rtl/bank_sched.sv
// bank_sched: round-robin arbiter that grants one requester at a time to a bank for HOLD cycles.
// Optional feature macro BANK_SCHED_LOCK_EN: req_lock in the ack cycle keeps that requester's priority.
module bank_sched #(
  parameter int NREQ  = 4,
  parameter int NBANK = 32,
  parameter int HOLD  = 3,
  localparam int A    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*A-1:0] req_addr,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [A-1:0]      bank_addr,
  output logic [NBANK-1:0]  csel,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(HOLD + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state_reg;
  logic [PW-1:0]    ptr_reg;
  logic [PW-1:0]    g_reg;
  logic [CW-1:0]    cnt_reg;
  logic [NREQ-1:0]  gnt_reg;
  logic [NREQ-1:0]  ack_reg;
  logic [A-1:0]     bank_addr_reg;
  logic [NBANK-1:0] csel_reg;

  logic             found;
  logic [PW-1:0]    pick;
  logic [A-1:0]     sel_addr;
  logic [NREQ-1:0]  gnt_dec;
  logic [NBANK-1:0] csel_dec;
  logic [PW-1:0]    ptr_adv;
  logic [PW-1:0]    ptr_ret;

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr_reg) + k) % NREQ]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr_reg) + k) % NREQ);
      end
    end
  end

  assign sel_addr = req_addr[int'(pick)*A +: A];
  assign gnt_dec  = NREQ'(1) << pick;

  // Addresses at or beyond NBANK match no decoder bit, leaving csel all zero.
  generate
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_dec
      assign csel_dec[gi] = (sel_addr == A'(gi));
    end
  endgenerate

  assign ptr_adv = (int'(g_reg) == NREQ - 1) ? '0 : g_reg + 1'b1;

`ifdef BANK_SCHED_LOCK_EN
  assign ptr_ret = req_lock[g_reg] ? g_reg : ptr_adv;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign ptr_ret     = ptr_adv;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      g_reg         <= '0;
      cnt_reg       <= '0;
      gnt_reg       <= '0;
      ack_reg       <= '0;
      bank_addr_reg <= '0;
      csel_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            state_reg     <= BUSY;
            g_reg         <= pick;
            gnt_reg       <= gnt_dec;
            bank_addr_reg <= sel_addr;
            csel_reg      <= csel_dec;
            cnt_reg       <= CW'(HOLD - 1);
            ack_reg       <= (HOLD == 1) ? gnt_dec : '0;
          end
        end
        default: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            csel_reg  <= '0;
            ack_reg   <= '0;
            ptr_reg   <= ptr_ret;
          end else begin
            // ack is registered, so raise it on the edge where cnt reaches zero.
            cnt_reg <= cnt_reg - 1'b1;
            ack_reg <= (cnt_reg == CW'(1)) ? gnt_reg : '0;
          end
        end
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign ack       = ack_reg;
  assign bank_addr = bank_addr_reg;
  assign csel      = csel_reg;
  assign busy      = (state_reg == BUSY);

endmodule

// File: tb/tb_bank_sched.sv
// Testbench for bank_sched: scoreboard of expected grants checked by a negedge monitor,
// plus a second instance (HOLD=1, NBANK=24) for the edge cases.
module tb_bank_sched;

  localparam int NREQ = 4;
  localparam int A    = 5;
  localparam int HOLD = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*A-1:0] req_addr = '0;
  logic [NREQ-1:0]   req_lock = '0;
  logic [NREQ-1:0]   gnt, ack;
  logic [A-1:0]      bank_addr;
  logic [31:0]       csel;
  logic              busy;

  logic [NREQ-1:0]   v1 = '0;
  logic [NREQ*A-1:0] a1 = '0;
  logic [NREQ-1:0]   l1 = '0;
  logic [NREQ-1:0]   g1, k1;
  logic [A-1:0]      ba1;
  logic [23:0]       cs1;
  logic              b1;

  bank_sched #(.NREQ(4), .NBANK(32), .HOLD(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_lock(req_lock),
    .gnt(gnt), .ack(ack), .bank_addr(bank_addr), .csel(csel), .busy(busy)
  );

  bank_sched #(.NREQ(4), .NBANK(24), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_addr(a1), .req_lock(l1),
    .gnt(g1), .ack(k1), .bank_addr(ba1), .csel(cs1), .busy(b1)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; int addr;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(int i, int a);
    exp_t e;
    e.idx  = i;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every grant cycle against the front of the scoreboard.
  bit in_grant = 0;
  bit prev_ack = 0;
  int cyc = 0;
  always @(negedge clk) begin
    logic [NREQ-1:0] eg, ea;
    logic [31:0]     ec;
    if (rst) begin
      if (in_grant) begin
        chk("reset_abort", {gnt, ack, csel, 7'd0, busy}, 64'd0);
        void'(exp_q.pop_front());
      end
      in_grant = 0;
      prev_ack = 0;
      cyc      = 0;
    end else if (gnt != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: got gnt=%b expected none", gnt);
      end else begin
        eg = NREQ'(1) << exp_q[0].idx;
        ec = 32'd1 << exp_q[0].addr;
        ea = (cyc == HOLD - 1) ? eg : '0;
        if (gnt !== eg || bank_addr !== A'(exp_q[0].addr) || csel !== ec || ack !== ea ||
            busy !== 1'b1 || prev_ack) begin
          errors++;
          $display("FAIL grant_cycle%0d: got gnt=%b addr=%0d csel=%h ack=%b busy=%b bubble_missing=%0d expected gnt=%b addr=%0d csel=%h ack=%b busy=1",
                   cyc, gnt, bank_addr, csel, ack, busy, prev_ack, eg, exp_q[0].addr, ec, ea);
        end
        in_grant = 1;
        prev_ack = 0;
        if (ack != '0 || cyc >= HOLD - 1) begin
          if (ack != '0) ack_cnt++;
          void'(exp_q.pop_front());
          in_grant = 0;
          prev_ack = 1;
          cyc      = 0;
        end else begin
          cyc++;
        end
      end
    end else begin
      if (in_grant || prev_ack)
        chk(in_grant ? "grant_dropped" : "idle_bubble", {ack, busy, 3'd0, in_grant}, 64'd0);
      in_grant = 0;
      prev_ack = 0;
      cyc      = 0;
    end
  end

  task automatic wait_acks(int target);
    int n = 0;
    while (ack_cnt < target && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("ack_count", ack_cnt, target);
  endtask

  task automatic set_addr(int i, int a);
    req_addr[i*A +: A] = A'(a);
  endtask

  initial begin
    int base;
    int n;
    repeat (2) @(negedge clk);
    chk("reset_state", {gnt, ack, bank_addr, csel, busy}, 64'd0);
    chk("reset_state_d1", {g1, k1, ba1, cs1, b1}, 64'd0);
    #1 rst = 1'b0;

    // HOLD=1 and NBANK=24: out-of-range address still grants, csel stays zero.
    @(posedge clk); #1;
    v1 = 4'b0001;
    a1[4:0] = 5'd30;
    @(negedge clk);
    chk("d1_latency_idle", g1, 4'b0000);
    @(negedge clk);
    chk("d1_oob_grant", {g1, k1, ba1, cs1, b1}, {4'b0001, 4'b0001, 5'd30, 24'd0, 1'b1});
    @(posedge clk); #1;
    a1[4:0] = 5'd23;
    @(negedge clk);
    chk("d1_bubble", {g1, k1, b1}, 9'd0);
    @(negedge clk);
    chk("d1_inrange_grant", {g1, k1, ba1, cs1, b1}, {4'b0001, 4'b0001, 5'd23, 24'h800000, 1'b1});
    @(posedge clk); #1;
    v1 = '0;

    // Single request, one-cycle latency.
    @(posedge clk); #1;
    req_valid = 4'b0001;
    set_addr(0, 5);
    push(0, 5);
    @(negedge clk);
    chk("latency_idle", {gnt, busy}, 5'd0);
    @(negedge clk);
    chk("latency_grant", gnt, 4'b0001);
    wait_acks(1);
    @(posedge clk); #1;
    req_valid = '0;

    // All requesting after reset: 0,1,2,3,0.
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_addr(i, i + 1);
    req_valid = 4'b1111;
    push(0, 1); push(1, 2); push(2, 3); push(3, 4); push(0, 1);
    wait_acks(6);
    @(posedge clk); #1;
    req_valid = '0;

    // Requester 2 alone moves ptr to 3.
    @(posedge clk); #1;
    req_valid = 4'b0100;
    set_addr(2, 9);
    push(2, 9);
    wait_acks(7);
    @(posedge clk); #1;
    req_valid = '0;

    // Reset in the 2nd grant cycle of requester 3; afterwards ptr=0 so requester 1 wins.
    @(posedge clk); #1;
    req_valid = 4'b1010;
    set_addr(1, 7);
    set_addr(3, 31);
    push(3, 31);
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (gnt == '0 && n < 50);
    chk("grant_before_reset", gnt, 4'b1000);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("async_reset", {gnt, ack, csel, busy}, 41'd0);
    @(negedge clk); #1 rst = 1'b0;
    push(1, 7);
    push(3, 31);
    wait_acks(9);
    @(posedge clk); #1;
    req_valid = '0;

    // Lock behaviour: ptr is 0 here.
    @(posedge clk); #1;
    req_valid = 4'b0011;
    req_lock  = 4'b0001;
    set_addr(0, 12);
    set_addr(1, 20);
`ifdef BANK_SCHED_LOCK_EN
    push(0, 12); push(0, 12); push(0, 12); push(0, 12);
`else
    push(0, 12); push(1, 20); push(0, 12); push(1, 20);
`endif
    base = 9;
    wait_acks(base + 4);
    @(posedge clk); #1;
    req_valid = '0;
    req_lock  = '0;

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("final_idle", {gnt, busy}, 5'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
